fp_exc_classifier: RTL and testbench

//  Streaming IEEE-754 operand classifier for the FPU front end. Accepts one packed float per

---
 rtl/fp_exc_pkg.sv | 50 +++++
 rtl/fp_exc_skid_buf.sv | 83 ++++++++
 rtl/fp_exc_classifier.sv | 91 +++++++++
 tb/tb_fp_exc_classifier.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_exc_pkg.sv
// Shared types and the IEEE-754 field classifier for the operand classifier block.
package fp_exc_pkg;

  localparam int MAX_EXP_W = 11;
  localparam int MAX_MAN_W = 52;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    ZERO    = 3'd1,
    SUBNORM = 3'd2,
    INF     = 3'd3,
    QNAN    = 3'd4,
    SNAN    = 3'd5
  } exc_code_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // exp/man arrive zero-extended; exp_w/man_w give the real field widths.
  function automatic exc_code_e classify(input logic [MAX_EXP_W-1:0] exp,
                                         input logic [MAX_MAN_W-1:0] man,
                                         input int exp_w,
                                         input int man_w);
    logic [MAX_EXP_W-1:0] emask;
    logic [MAX_MAN_W-1:0] shifted;
    logic                 exp_ones;
    logic                 exp_zero;
    logic                 man_zero;
    logic                 man_msb;
    emask = '0;
    for (int i = 0; i < MAX_EXP_W; i++) begin
      if (i < exp_w) emask[i] = 1'b1;
    end
    shifted  = man >> (man_w - 1);
    exp_ones = ((exp & emask) == emask);
    exp_zero = ((exp & emask) == '0);
    man_zero = (man == '0);
    man_msb  = shifted[0];
    if (exp_ones && man_zero)      return INF;
    else if (exp_ones && man_msb)  return QNAN;
    else if (exp_ones)             return SNAN;
    else if (exp_zero && man_zero) return ZERO;
    else if (exp_zero)             return SUBNORM;
    else                           return NONE;
  endfunction

endpackage

// File: rtl/fp_exc_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered in_ready; exposes its FSM state.
module fp_exc_skid_buf
  import fp_exc_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  input  logic          out_ready,
  output buf_state_e    state
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // in_ready depends only on registered state, never on in_valid/out_ready.
  buf_state_e    state_d;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  logic          load_head_in;
  logic          load_head_tail;
  logic          load_tail;

  assign push = in_valid & in_ready;
  assign pop  = (state != EMPTY) & out_ready;

  always_comb begin
    state_d        = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = FULL;
          load_tail = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_head_in = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_d;
      in_ready <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_payload <= '0;
      tail        <= '0;
    end else begin
      if (load_head_in)        out_payload <= in_payload;
      else if (load_head_tail) out_payload <= tail;
      if (load_tail)           tail        <= in_payload;
    end
  end

endmodule

// File: rtl/fp_exc_classifier.sv
// Streaming IEEE-754 operand classifier with sequence tags and a 2-entry skid buffer.
// Optional sticky per-class flags are built when EXC_STICKY_EN is defined.
module fp_exc_classifier
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_sign,
  output logic [2:0]             out_exc,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef EXC_STICKY_EN
  ,
  output logic [4:0]             sticky_flags,
  input  logic                   sticky_clr
`endif
);

  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int PW = TAG_W + 3 + DW;

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  exc_code_e        in_exc;
  logic             accept;
  logic [TAG_W-1:0] tag_cnt;
  logic [PW-1:0]    out_payload;
  buf_state_e       buf_state;

  assign exp_f  = in_data[DW-2:MAN_W];
  assign man_f  = in_data[MAN_W-1:0];
  assign in_exc = classify(MAX_EXP_W'(exp_f), MAX_MAN_W'(man_f), EXP_W, MAN_W);
  assign accept = in_valid & in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tag_cnt <= '0;
    else if (accept) tag_cnt <= tag_cnt + TAG_W'(1);
  end

  fp_exc_skid_buf #(.PW(PW)) u_buf (
    .clk        (CLK),
    .rst        (RST),
    .in_payload ({tag_cnt, in_exc, in_data}),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_payload(out_payload),
    .out_ready  (out_ready),
    .state      (buf_state)
  );

  assign out_valid = (buf_state != EMPTY);
  assign out_data  = out_payload[DW-1:0];
  assign out_exc   = out_payload[DW+2:DW];
  assign out_tag   = out_payload[PW-1:DW+3];
  assign out_sign  = out_payload[DW-1];

`ifdef EXC_STICKY_EN
  logic [4:0] sticky_set;

  always_comb begin
    sticky_set = '0;
    if (accept) begin
      unique case (in_exc)
        ZERO:    sticky_set[0] = 1'b1;
        SUBNORM: sticky_set[1] = 1'b1;
        INF:     sticky_set[2] = 1'b1;
        QNAN:    sticky_set[3] = 1'b1;
        SNAN:    sticky_set[4] = 1'b1;
        default: sticky_set    = '0;
      endcase
    end
  end

  // A set landing in the same cycle as a clear survives the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sticky_flags <= '0;
    else if (sticky_clr) sticky_flags <= sticky_set;
    else sticky_flags <= sticky_flags | sticky_set;
  end
`endif

endmodule

// File: tb/tb_fp_exc_classifier.sv
// Scoreboard bench for fp_exc_classifier: binary32 instance plus a binary16 instance.
module tb_fp_exc_classifier;

  localparam int SW = 4 + 3 + 32;
  localparam int HW = 4 + 3 + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sign;
  logic [2:0]  out_exc;
  logic [3:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  sticky_flags;
  logic        sticky_clr;

  logic [15:0] h_in_data;
  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_out_data;
  logic        h_out_sign;
  logic [2:0]  h_out_exc;
  logic [3:0]  h_out_tag;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [4:0]  h_sticky_flags;

  fp_exc_classifier #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .CLK(clk), .RST(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sign(out_sign), .out_exc(out_exc),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
`ifdef EXC_STICKY_EN
    , .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
`endif
  );

  fp_exc_classifier #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .CLK(clk), .RST(rst),
    .in_data(h_in_data), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .out_data(h_out_data), .out_sign(h_out_sign), .out_exc(h_out_exc),
    .out_tag(h_out_tag), .out_valid(h_out_valid), .out_ready(h_out_ready)
`ifdef EXC_STICKY_EN
    , .sticky_flags(h_sticky_flags), .sticky_clr(1'b0)
`endif
  );

`ifndef EXC_STICKY_EN
  assign sticky_flags   = '0;
  assign h_sticky_flags = '0;
`endif

  int checks = 0;
  int fails = 0;
  int pop_count = 0;
  logic [SW-1:0] exp_q[$];
  logic [HW-1:0] exp_h_q[$];
  logic [3:0]    model_tag = '0;
  logic [3:0]    model_h_tag = '0;
  logic [4:0]    model_sticky = '0;
  bit            bp_rand = 0;

  // Reference: decode the fields arithmetically and apply the class rules.
  function automatic int ref_class(longint unsigned x, int ew, int mw);
    longint unsigned e, m, emax;
    emax = (64'd1 << ew) - 1;
    e = (x >> mw) & emax;
    m = x & ((64'd1 << mw) - 1);
    if (e == emax) begin
      if (m == 0) return 3;
      if (m >= (64'd1 << (mw - 1))) return 4;
      return 5;
    end
    if (e == 0) return (m == 0) ? 1 : 2;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] rand_f32();
    logic [31:0] x;
    logic        s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: x = {s, 8'h00, 23'h0};
      1: x = {s, 8'h00, 23'($urandom_range(1, 32'h7fffff))};
      2: x = {s, 8'hff, 23'h0};
      3: x = {s, 8'hff, 1'b1, 22'($urandom)};
      4: x = {s, 8'hff, 1'b0, 22'($urandom_range(1, 32'h3fffff))};
      5: x = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      default: x = $urandom;
    endcase
    return x;
  endfunction

  function automatic logic [15:0] rand_f16();
    logic [4:0] e;
    case ($urandom_range(0, 3))
      0: e = 5'd0;
      1: e = 5'd31;
      default: e = 5'($urandom);
    endcase
    return {1'($urandom), e, 10'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
  endfunction

  task automatic on_accept(input logic [31:0] d);
    int c;
    logic [4:0] set;
    c = ref_class(64'(d), 8, 23);
    exp_q.push_back({model_tag, 3'(c), d});
    model_tag = model_tag + 4'd1;
    set = (c == 0) ? 5'd0 : (5'd1 << (c - 1));
    if (sticky_clr) model_sticky = set;
    else model_sticky = model_sticky | set;
  endtask

  task automatic send(input logic [31:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        on_accept(d);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) note_fail("send_timeout");
  endtask

  task automatic send_h(input logic [15:0] d);
    bit done;
    int c;
    done = 0;
    h_in_valid = 1'b1;
    h_in_data = d;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (h_in_ready) begin
        c = ref_class(64'(d), 5, 10);
        exp_h_q.push_back({model_h_tag, 3'(c), d});
        model_h_tag = model_h_tag + 4'd1;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) note_fail("send_h_timeout");
  endtask

  task automatic idle();
    in_valid = 1'b0;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) note_fail("drain_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_h_q.delete();
    model_tag = '0;
    model_h_tag = '0;
    model_sticky = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the head every cycle it is presented, pop on transfer.
  always @(negedge clk) begin : mon
    logic [SW-1:0] e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) note_fail("unexpected_output");
      else begin
        e = exp_q[0];
        check("out_data", 64'(out_data), 64'(e[31:0]));
        check("out_exc", 64'(out_exc), 64'(e[34:32]));
        check("out_tag", 64'(out_tag), 64'(e[38:35]));
        check("out_sign", 64'(out_sign), 64'(e[31]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_count++;
        end
      end
    end
  end

  always @(negedge clk) begin : mon_h
    logic [HW-1:0] e;
    if (!rst && h_out_valid) begin
      if (exp_h_q.size() == 0) note_fail("h_unexpected_output");
      else begin
        e = exp_h_q[0];
        check("h_out_data", 64'(h_out_data), 64'(e[15:0]));
        check("h_out_exc", 64'(h_out_exc), 64'(e[18:16]));
        check("h_out_tag", 64'(h_out_tag), 64'(e[22:19]));
        check("h_out_sign", 64'(h_out_sign), 64'(e[15]));
        if (h_out_ready) void'(exp_h_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    time t0;
    int  p0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    h_in_valid = 1'b0;
    h_in_data = '0;
    h_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_exc", 64'(out_exc), 64'd0);
    check("rst_out_sign", 64'(out_sign), 64'd0);
`ifdef EXC_STICKY_EN
    check("rst_sticky", 64'(sticky_flags), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Directed class table.
    out_ready = 1'b1;
    send(32'h0000_0000);
    send(32'h0000_0001);
    send(32'h3F80_0000);
    send(32'hFF80_0000);
    send(32'h7FC0_0000);
    send(32'h7F80_0001);
    idle();
    drain();

    // Throughput and tag wrap: 17 back-to-back operands from tag 0.
    do_reset();
    out_ready = 1'b1;
    t0 = $time;
    p0 = pop_count;
    for (int i = 0; i < 17; i++) send(rand_f32());
    idle();
    check("thru_cycles", 64'(($time - t0) / 10), 64'd17);
    check("thru_pops", 64'(pop_count - p0), 64'd16);
    drain();

    // Backpressure: two accepted, third stalls while outputs hold.
    out_ready = 1'b0;
    send(32'h4000_0000);
    send(32'h0040_0000);
    in_valid = 1'b1;
    in_data = 32'h7F80_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h7F80_0000);
    idle();
    drain();

    // Reset with a full buffer.
    out_ready = 1'b0;
    send(rand_f32());
    send(rand_f32());
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    exp_h_q.delete();
    model_tag = '0;
    model_h_tag = '0;
    model_sticky = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h3F80_0000);
    idle();
    drain();

`ifdef EXC_STICKY_EN
    do_reset();
    out_ready = 1'b1;
    send(32'h7FC0_0000);
    send(32'hFF80_0000);
    idle();
    @(posedge clk);
    #1;
    check("sticky_qnan_inf", 64'(sticky_flags), 64'(model_sticky));
    sticky_clr = 1'b1;
    send(32'h7F80_0001);
    sticky_clr = 1'b0;
    idle();
    @(posedge clk);
    #1;
    check("sticky_clr_set", 64'(sticky_flags), 64'(model_sticky));
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    model_sticky = '0;
    check("sticky_clr_only", 64'(sticky_flags), 64'(model_sticky));
    drain();
`endif

    // Randomized traffic with random backpressure.
    bp_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end else begin
        send(rand_f32());
      end
    end
    idle();
    bp_rand = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
`ifdef EXC_STICKY_EN
    check("sticky_random", 64'(sticky_flags), 64'(model_sticky));
`endif

    // Half-precision instance.
    send_h(16'h7C00);
    send_h(16'h7E00);
    send_h(16'h0200);
    send_h(16'hFC00);
    send_h(16'h7C01);
    send_h(16'h3C00);
    for (int i = 0; i < 40; i++) send_h(rand_f16());
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
